// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier controller.
package mult_pkg;

    localparam int WIDTH     = 32;
    localparam int CNT_W     = 6;
    localparam int LAST_ITER = WIDTH - 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/datapath.sv
// One shift-add step of a 32x32 unsigned multiply: conditionally add the
// multiplicand into the upper half, then shift the whole 65-bit value right by one.
module datapath (
    input  logic [31:0] mult,
    input  logic [63:0] inP,
    input  logic        write,
    output logic [63:0] outP
);

    logic [32:0] sum;

    always_comb begin
        // The 33rd bit keeps the carry so it lands in outP[63] after the shift.
        sum  = write ? ({1'b0, inP[63:32]} + {1'b0, mult}) : {1'b0, inP[63:32]};
        outP = {sum, inP[31:1]};
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// Start/busy/done sequencer around the shift-add datapath: one 32x32 unsigned
// multiply per request, result valid 33 clocks after the accepting edge.
module mult_seq_ctrl #(
    parameter int WIDTH = mult_pkg::WIDTH,
    parameter int CNT_W = mult_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [CNT_W-1:0]     iter
);

    import mult_pkg::*;

    localparam logic [CNT_W-1:0] ITER_END = CNT_W'(LAST_ITER);

    state_e               state_q;
    logic                 busy_q;
    logic                 done_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH-1:0]   product_q;
    logic [2*WIDTH-1:0]   product_d;
    logic [CNT_W-1:0]     iter_q;

    datapath u_datapath (
        .mult  (mcand_q),
        .inP   (product_q),
        .write (product_q[0]),
        .outP  (product_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mcand_q   <= '0;
            product_q <= '0;
            iter_q    <= '0;
        end else begin
            // NOTE: non-blocking everywhere here so every register samples pre-edge values.
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q   <= multiplicand;
                        product_q <= {{WIDTH{1'b0}}, multiplier};
                        iter_q    <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    // Abort leaves the partial product and count visible for debug.
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        product_q <= product_d;
                        iter_q    <= iter_q + CNT_W'(1);
                        if (iter_q == ITER_END) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
    assign iter    = iter_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: expected products are queued at accept
// and popped when done pulses; inputs driven and outputs sampled on negedge.
module tb_mult_seq_ctrl;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               abort;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;
    logic [CNT_W-1:0]   iter;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];

    mult_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .iter         (iter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Independent shift-add reference step, used only to predict an aborted partial product.
    function automatic logic [63:0] ref_step(input logic [63:0] p, input logic [31:0] m);
        logic [32:0] s;
        s = {1'b0, p[63:32]} + (p[0] ? {1'b0, m} : 33'd0);
        return {s, p[31:1]};
    endfunction

    // Drives one start pulse (consumes the accepting edge) and optionally queues the product.
    task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input bit push);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        if (push) exp_q.push_back({32'd0, a} * {32'd0, b});
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    // Waits (bounded) for done; cyc0 is the number of cycles already elapsed since accept.
    task automatic wait_done(input string tag, input int cyc0);
        int cyc;
        logic [63:0] exp;
        cyc = cyc0;
        while (done !== 1'b1 && cyc < 45) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd33);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_product"}, product, exp);
        end
        check({tag, "_iter"}, 64'(iter), 64'd32);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [63:0] partial;
        int k;
        bit seen_done;

        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_product", product, 64'd0);
        check("reset_iter", 64'(iter), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic 12x8, then single-cycle done with held results.
        drive_start(32'd12, 32'd8, 1'b1);
        wait_done("m12x8", 1);
        @(negedge clk);
        check("m12x8_done_one_cycle", {63'd0, done}, 64'd0);
        check("m12x8_product_held", product, 64'd96);
        check("m12x8_iter_held", 64'(iter), 64'd32);

        // Maximum operands: carry into bit 63.
        drive_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("max", 1);
        @(negedge clk);

        drive_start(32'h1234_5678, 32'd0, 1'b1);
        wait_done("mul_zero", 1);
        @(negedge clk);

        // Abort together with start in IDLE: start wins.
        abort = 1'b1;
        drive_start(32'h1234_5678, 32'd1, 1'b1);
        abort = 1'b0;
        wait_done("mul_one", 1);
        @(negedge clk);

        // Start while busy is ignored; start in the done cycle is accepted.
        drive_start(32'd5, 32'd7, 1'b1);
        repeat (8) @(negedge clk);
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_busy", 10);
        drive_start(32'd9, 32'd9, 1'b1);
        wait_done("back_to_back", 1);
        @(negedge clk);

        // Abort at iter 15: partial product and count held, no done.
        drive_start(32'd100, 32'd100, 1'b0);
        k = 0;
        while (iter !== 6'd15 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("abort_reach_iter15", 64'(iter), 64'd15);
        partial = {32'd0, 32'd100};
        for (int i = 0; i < 15; i++) partial = ref_step(partial, 32'd100);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_iter", 64'(iter), 64'd15);
        check("abort_partial", product, partial);
        seen_done = (done === 1'b1);
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("abort_no_done", {63'd0, seen_done}, 64'd0);
        check("abort_iter_held", 64'(iter), 64'd15);
        drive_start(32'd3, 32'd4, 1'b1);
        wait_done("after_abort", 1);
        @(negedge clk);

        // Asynchronous reset mid-run.
        drive_start(32'd100, 32'd100, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_product", product, 64'd0);
        check("midrst_iter", 64'(iter), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("midrst_no_done", {63'd0, seen_done}, 64'd0);
        drive_start(32'd6, 32'd7, 1'b1);
        wait_done("after_reset", 1);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
